// File: rtl/interrupt_request_arbiter_pkg.sv
// Shared types for the interrupt request arbiter.
// Vector select and arbiter state encodings.
package control_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    VEC_NONE = 2'd0,
    VEC_NMI  = 2'd1,
    VEC_IRQ  = 2'd2
  } vector_sel_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACK     = 2'd1,
    ARB_SERVICE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/interrupt_request_arbiter_if.sv
// Pin, decoder and vector-mux signals of the interrupt front end.
// master drives pins/decoder strobes; slave is the arbiter.
interface interrupt_request_arbiter_if;
  import control_pkg::*;

  logic        enableFFs;
  logic        nmiPin;
  logic        irqPin;
  logic        processStatusRegIFlag;
  logic        instructionBoundary;
  logic        vectorFetchDone;
  logic        synchronizedNMI;
  logic        nmiGenerated;
  logic        interruptAcknowleged;
  vector_sel_t vectorSelect;

  modport master (
    output enableFFs,
    output nmiPin,
    output irqPin,
    output processStatusRegIFlag,
    output instructionBoundary,
    output vectorFetchDone,
    input  synchronizedNMI,
    input  nmiGenerated,
    input  interruptAcknowleged,
    input  vectorSelect
  );

  modport slave (
    input  enableFFs,
    input  nmiPin,
    input  irqPin,
    input  processStatusRegIFlag,
    input  instructionBoundary,
    input  vectorFetchDone,
    output synchronizedNMI,
    output nmiGenerated,
    output interruptAcknowleged,
    output vectorSelect
  );

endinterface

// File: rtl/interrupt_request_arbiter_sync_chain.sv
// Multi-flop synchroniser for one asynchronous pin.
// Free-running: clocks every cycle regardless of cycle enable.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/interrupt_request_arbiter.sv
// Interrupt front end: pin sync, NMI edge latch,
// NMI > IRQ arbitration at instruction boundaries.
module interrupt_request_arbiter
  import control_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic                         clk,
  input logic                         nrst,
  interrupt_request_arbiter_if.slave  bus
);

  logic        nmiSync;
  logic        irqSync;
  logic        nmiHist;
  logic        nmiEdge;
  logic        irqPending;
  logic        nmiGen;
  logic        nmiGenNext;
  logic        ack;
  logic        ackNext;
  vector_sel_t vecSel;
  vector_sel_t vecNext;
  arb_state_t  state;
  arb_state_t  stateNext;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) uNmiSync (
    .clk  (clk),
    .nrst (nrst),
    .d    (bus.nmiPin),
    .q    (nmiSync)
  );

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) uIrqSync (
    .clk  (clk),
    .nrst (nrst),
    .d    (bus.irqPin),
    .q    (irqSync)
  );

  assign nmiEdge    = nmiHist & ~nmiSync;
  assign irqPending = ~irqSync & ~bus.processStatusRegIFlag;

  always_comb begin
    stateNext  = state;
    vecNext    = vecSel;
    ackNext    = 1'b0;
    // A fresh edge in the clearing cycle wins over the clear.
    nmiGenNext = nmiEdge |
                 (nmiGen & ~(state == ARB_ACK && vecSel == VEC_NMI));
    unique case (state)
      ARB_IDLE: begin
        if (bus.instructionBoundary && (nmiGen || irqPending)) begin
          stateNext = ARB_ACK;
          ackNext   = 1'b1;
          vecNext   = nmiGen ? VEC_NMI : VEC_IRQ;
        end
      end
      ARB_ACK: begin
        stateNext = ARB_SERVICE;
      end
      ARB_SERVICE: begin
        if (bus.vectorFetchDone) begin
          stateNext = ARB_IDLE;
          vecNext   = VEC_NONE;
        end
      end
      default: begin
        stateNext = ARB_IDLE;
        vecNext   = VEC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ARB_IDLE;
      vecSel  <= VEC_NONE;
      ack     <= 1'b0;
      nmiGen  <= 1'b0;
      nmiHist <= 1'b1;
    end else if (bus.enableFFs) begin
      state   <= stateNext;
      vecSel  <= vecNext;
      ack     <= ackNext;
      nmiGen  <= nmiGenNext;
      nmiHist <= nmiSync;
    end
  end

  assign bus.synchronizedNMI      = ~nmiSync;
  assign bus.nmiGenerated         = nmiGen;
  assign bus.interruptAcknowleged = ack;
  assign bus.vectorSelect         = vecSel;

endmodule

// File: tb/tb_interrupt_request_arbiter.sv
// Directed bench for interrupt_request_arbiter.
// Expected acks queued by stimulus, checked by monitor.
module tb_interrupt_request_arbiter;
  import control_pkg::*;

  logic clk;
  logic nrst;
  int   nChecks = 0;
  int   nPass   = 0;
  int   expQ[$];

  interrupt_request_arbiter_if ifc();

  interrupt_request_arbiter #(
    .SYNC_STAGES (2)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic boundary();
    ifc.instructionBoundary = 1'b1;
    tick(1);
    ifc.instructionBoundary = 1'b0;
  endtask

  task automatic fetchDone();
    ifc.vectorFetchDone = 1'b1;
    tick(1);
    ifc.vectorFetchDone = 1'b0;
  endtask

  always @(negedge clk) begin
    if (nrst && ifc.interruptAcknowleged && ifc.enableFFs) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("FAIL unexpected_ack: got vector %0d expected no ack",
                 int'(ifc.vectorSelect));
      end else begin
        chk("ack_vector", int'(ifc.vectorSelect), expQ.pop_front());
      end
    end
  end

  initial begin
    nrst                      = 1'b0;
    ifc.enableFFs             = 1'b1;
    ifc.nmiPin                = 1'b1;
    ifc.irqPin                = 1'b1;
    ifc.processStatusRegIFlag = 1'b1;
    ifc.instructionBoundary   = 1'b0;
    ifc.vectorFetchDone       = 1'b0;
    tick(2);
    chk("rst_nmiGen", int'(ifc.nmiGenerated), 0);
    chk("rst_ack", int'(ifc.interruptAcknowleged), 0);
    chk("rst_vec", int'(ifc.vectorSelect), 0);
    chk("rst_syncNmi", int'(ifc.synchronizedNMI), 0);
    nrst = 1'b1;

    // 1: idle pins, periodic boundaries
    for (int i = 0; i < 4; i++) begin
      tick(4);
      boundary();
    end
    chk("t1_nmiGen", int'(ifc.nmiGenerated), 0);
    chk("t1_vec", int'(ifc.vectorSelect), 0);

    // 2: NMI edge latency and service
    ifc.nmiPin = 1'b0;
    tick(1);
    chk("t2_sync_t1", int'(ifc.synchronizedNMI), 0);
    tick(1);
    chk("t2_sync_t2", int'(ifc.synchronizedNMI), 1);
    chk("t2_gen_t2", int'(ifc.nmiGenerated), 0);
    tick(1);
    chk("t2_gen_t3", int'(ifc.nmiGenerated), 1);
    tick(2);
    expQ.push_back(1);
    boundary();
    chk("t2_ack", int'(ifc.interruptAcknowleged), 1);
    chk("t2_vec", int'(ifc.vectorSelect), 1);
    tick(1);
    chk("t2_ack_end", int'(ifc.interruptAcknowleged), 0);
    chk("t2_gen_clr", int'(ifc.nmiGenerated), 0);
    chk("t2_vec_hold", int'(ifc.vectorSelect), 1);
    ifc.nmiPin = 1'b1;
    fetchDone();
    chk("t2_vec_none", int'(ifc.vectorSelect), 0);
    tick(3);

    // 3: masked IRQ, then unmasked, then level re-ack
    ifc.irqPin = 1'b0;
    tick(3);
    boundary();
    tick(1);
    boundary();
    chk("t3_masked_ack", int'(ifc.interruptAcknowleged), 0);
    chk("t3_masked_vec", int'(ifc.vectorSelect), 0);
    ifc.processStatusRegIFlag = 1'b0;
    expQ.push_back(2);
    boundary();
    chk("t3_ack", int'(ifc.interruptAcknowleged), 1);
    chk("t3_vec", int'(ifc.vectorSelect), 2);
    tick(1);
    fetchDone();
    chk("t3_vec_none", int'(ifc.vectorSelect), 0);
    chk("t3_no_b2b", int'(ifc.interruptAcknowleged), 0);
    expQ.push_back(2);
    boundary();
    chk("t3_reack", int'(ifc.interruptAcknowleged), 1);
    tick(1);
    fetchDone();
    ifc.irqPin                = 1'b1;
    ifc.processStatusRegIFlag = 1'b1;
    tick(3);

    // 4: NMI beats IRQ, IRQ follows
    ifc.irqPin                = 1'b0;
    ifc.processStatusRegIFlag = 1'b0;
    ifc.nmiPin                = 1'b0;
    tick(3);
    chk("t4_gen", int'(ifc.nmiGenerated), 1);
    expQ.push_back(1);
    boundary();
    chk("t4_vec_nmi", int'(ifc.vectorSelect), 1);
    tick(1);
    fetchDone();
    expQ.push_back(2);
    boundary();
    chk("t4_vec_irq", int'(ifc.vectorSelect), 2);
    tick(1);
    fetchDone();
    ifc.irqPin                = 1'b1;
    ifc.processStatusRegIFlag = 1'b1;
    ifc.nmiPin                = 1'b1;
    tick(3);

    // 5: edges during service and coincident with ack
    ifc.nmiPin = 1'b0;
    tick(3);
    expQ.push_back(1);
    boundary();
    tick(1);
    chk("t5_gen_clr", int'(ifc.nmiGenerated), 0);
    ifc.nmiPin = 1'b1;
    tick(3);
    ifc.nmiPin = 1'b0;
    tick(3);
    chk("t5_gen_in_svc", int'(ifc.nmiGenerated), 1);
    boundary();
    chk("t5_bnd_ign_ack", int'(ifc.interruptAcknowleged), 0);
    chk("t5_bnd_ign_vec", int'(ifc.vectorSelect), 1);
    ifc.nmiPin = 1'b1;
    tick(3);
    fetchDone();
    chk("t5_vec_none", int'(ifc.vectorSelect), 0);
    chk("t5_gen_kept", int'(ifc.nmiGenerated), 1);
    ifc.nmiPin = 1'b0;
    tick(1);
    expQ.push_back(1);
    boundary();
    chk("t5_ack2", int'(ifc.interruptAcknowleged), 1);
    tick(1);
    chk("t5_coinc_gen", int'(ifc.nmiGenerated), 1);
    chk("t5_coinc_ack", int'(ifc.interruptAcknowleged), 0);
    fetchDone();
    expQ.push_back(1);
    boundary();
    tick(1);
    chk("t5_gen_clr3", int'(ifc.nmiGenerated), 0);
    fetchDone();
    ifc.nmiPin = 1'b1;
    tick(3);

    // 6: freeze during ack, then reset in service
    ifc.irqPin                = 1'b0;
    ifc.processStatusRegIFlag = 1'b0;
    tick(3);
    expQ.push_back(2);
    boundary();
    ifc.enableFFs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t6_frozen_ack", int'(ifc.interruptAcknowleged), 1);
    end
    chk("t6_frozen_vec", int'(ifc.vectorSelect), 2);
    ifc.enableFFs = 1'b1;
    tick(1);
    chk("t6_ack_done", int'(ifc.interruptAcknowleged), 0);
    chk("t6_vec_svc", int'(ifc.vectorSelect), 2);
    ifc.nmiPin = 1'b0;
    tick(3);
    chk("t6_gen_pre", int'(ifc.nmiGenerated), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_rst_gen", int'(ifc.nmiGenerated), 0);
    chk("t6_rst_ack", int'(ifc.interruptAcknowleged), 0);
    chk("t6_rst_vec", int'(ifc.vectorSelect), 0);
    chk("t6_rst_sync", int'(ifc.synchronizedNMI), 0);
    ifc.nmiPin                = 1'b1;
    ifc.irqPin                = 1'b1;
    ifc.processStatusRegIFlag = 1'b1;
    tick(2);
    nrst = 1'b1;
    tick(4);
    chk("t6_post_gen", int'(ifc.nmiGenerated), 0);
    chk("t6_post_vec", int'(ifc.vectorSelect), 0);

    tick(2);
    chk("queue_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
